// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the register-file read stage and the multiply/divide unit.
// The master drives the request and MTHI/MTLO side; the slave returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] WD;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, hi_we, lo_we, WD,
        input  busy, done, dz, HI, LO
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, WD,
        output busy, done, dz, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on accept; signs are restored in the FINISH cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             op_div, op_signed, sign_a, sign_b;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] divisor;   // multiplicand for multiplies
    logic [WIDTH:0]   work_hi;   // partial product high half / remainder
    logic [WIDTH-1:0] work_lo;   // multiplier / quotient
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod, prod_res;
    logic [WIDTH-1:0]   quot_res, rem_res;
    logic               dz_now;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = CALC;
            CALC:    if (cnt == CW'(ITER - 1)) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    always_comb begin
        add_sum = work_hi + (work_lo[0] ? {1'b0, divisor} : '0);
        shifted = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
    end

    always_comb begin
        prod     = {work_hi[WIDTH-1:0], work_lo};
        prod_res = (op_signed && (sign_a ^ sign_b)) ? -prod : prod;
        quot_res = (op_signed && (sign_a ^ sign_b)) ? -work_lo : work_lo;
        rem_res  = (op_signed && sign_a) ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];
        dz_now   = op_div && (divisor == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            a_raw     <= '0;
            divisor   <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.WD;
                    if (bus.lo_we) lo_q <= bus.WD;
                    if (bus.start) begin
                        op_div    <= bus.op[1];
                        op_signed <= bus.op[0];
                        sign_a    <= bus.op[0] & bus.A[WIDTH-1];
                        sign_b    <= bus.op[0] & bus.B[WIDTH-1];
                        a_raw     <= bus.A;
                        work_lo   <= (bus.op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
                        divisor   <= (bus.op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;
                        work_hi   <= '0;
                        cnt       <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        work_hi <= diff[WIDTH+1] ? shifted : diff[WIDTH:0];
                        work_lo <= {work_lo[WIDTH-2:0], ~diff[WIDTH+1]};
                    end else begin
                        work_hi <= {1'b0, add_sum[WIDTH:1]};
                        work_lo <= {add_sum[0], work_lo[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    dz_q   <= dz_now;
                    if (dz_now) begin
                        // Divide by zero reports the untouched dividend, not its magnitude.
                        hi_q <= a_raw;
                        lo_q <= '1;
                    end else if (op_div) begin
                        hi_q <= rem_res;
                        lo_q <= quot_res;
                    end else begin
                        hi_q <= prod_res[2*WIDTH-1:WIDTH];
                        lo_q <= prod_res[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, signed/unsigned results,
// divide-by-zero, busy-time interference, back-to-back issue, async reset and MTHI/MTLO.
module tb_mult_div_unit;
    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Called at a negedge; leaves the bench at the negedge right after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int cyc, busy_cyc;
        start_op(op, a, b);
        wait_done(cyc, busy_cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
        check({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
        check({tag, "_dz"}, 64'(bus.dz), 64'(exp_dz));
    endtask

    initial begin
        int  cyc, busy_cyc;
        logic saw_done;
        n_checks  = 0;
        n_pass    = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.WD    = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_hi", 64'(bus.HI), 64'd0);
        check("rst_lo", 64'(bus.LO), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.dz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_11_10", DIVU, 32'd11, 32'd10, 32'd1, 32'd1, 1'b0);
        run_op("divu_dz", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        check("dz_hold", 64'(bus.dz), 64'd1);
        check("done_pulse", 64'(bus.done), 64'd0);
        run_op("multu_2_3", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        // Start and MTHI attempts while busy must leave the running op and HI untouched.
        start_op(MULTU, 32'd7, 32'd9);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            if (cyc == 5 || cyc == 20) begin
                bus.start = 1'b1;
                bus.op    = DIV;
                bus.A     = 32'd1000;
                bus.B     = 32'd3;
                bus.hi_we = 1'b1;
                bus.WD    = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            if (cyc == 6) check("mthi_ignored_busy", 64'(bus.HI), 64'd0);
        end
        check("busy_start_latency", 64'(cyc), 64'd33);
        check("multu_7_9_hi", 64'(bus.HI), 64'd0);
        check("multu_7_9_lo", 64'(bus.LO), 64'd63);

        // Back-to-back: issue the next op in the done cycle.
        run_op("divu_b2b", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Asynchronous reset mid-divide.
        start_op(DIV, 32'hFFFF_FF9C, 32'd3);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(bus.HI), 64'd0);
        check("arst_lo", 64'(bus.LO), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done |= bus.done;
        end
        check("arst_no_done", 64'(saw_done), 64'd0);
        check("arst_idle", 64'(bus.busy), 64'd0);

        run_op("mult_m1_m1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);

        // MTLO then MTHI in idle.
        bus.lo_we = 1'b1;
        bus.WD    = 32'h0000_1234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_lo", 64'(bus.LO), 64'h1234);
        check("mtlo_done", 64'(bus.done), 64'd0);
        bus.hi_we = 1'b1;
        bus.WD    = 32'h0000_ABCD;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_hi", 64'(bus.HI), 64'hABCD);
        check("mthi_lo_kept", 64'(bus.LO), 64'h1234);
        check("mthi_done", 64'(bus.done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Sequential multiply/divide unit directly downstream of the register file. It takes the two register read operands (DR1 = rs, DR2 = rt), runs MIPS MULT/MULTU/DIV/DIVU over 32 iterations, and holds the 64-bit result in architectural HI/LO registers. HI/LO feed the writeback mux (MFHI/MFLO), and MTHI/MTLO data arrives from the write-data path.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  32  rs operand (from DR1)
- B  in  32  rt operand (from DR2)
- hi_we  in  1  MTHI: write WD into HI
- lo_we  in  1  MTLO: write WD into LO
- WD  in  32  data for MTHI/MTLO
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- dz  out  1  divide-by-zero flag, valid only with done
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset: clk and rst_n are the only clock and reset. One clock; reset is asynchronous and active-low. rst_n=0 immediately forces HI=0, LO=0, busy=0, done=0, dz=0, state=IDLE and iteration counter=0. Asserting it mid-operation aborts the operation; no partial result survives.
- States:
  - IDLE: busy=0. start=1 at an edge latches A, B and op, records the operand signs, converts signed operands to magnitudes, clears cnt and moves to CALC.
  - CALC: busy=1. Each edge performs one shift-add step (multiply) or one restoring shift-subtract step (divide) and increments cnt. The edge with cnt==ITER-1 moves to FINISH.
  - FINISH: busy=1. The next edge applies the sign correction, writes HI/LO, pulses done=1 for one cycle, sets dz and returns to IDLE.
- Latency: start accepted at edge T0; iterations at T1..T32; HI/LO written at T33. busy is high from after T0 until T33. done is high only in the cycle after T33.
- start while busy=1 is ignored; it is neither queued nor stored. start in the cycle where done=1 is accepted, so back-to-back operations are legal. A/B/op may change freely after the accept edge.
- Multiply results:
  - MULTU: {HI,LO} = A*B, unsigned, 64 bits.
  - MULT: two's-complement 64-bit product. It is negated at FINISH when the operand signs differ.
- Divide results:
  - DIVU: LO = quotient, HI = remainder.
  - DIV: the quotient truncates toward zero. The remainder takes the sign of the dividend. Negation is applied at FINISH.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, dz=0.
- Divide by zero (B==0, DIV or DIVU): the operation still takes the full 33 cycles. Result is LO=0xFFFFFFFF, HI=A (unmodified dividend), dz=1 with done. Multiplies always report dz=0.
- dz holds its value until the next done or reset. done itself is a single-cycle pulse.
- MTHI/MTLO: hi_we/lo_we take effect at the next edge only while busy=0; while busy=1 they are ignored. If start and hi_we/lo_we arrive in the same IDLE cycle, the MT write completes and the operation starts. The later FINISH write overwrites HI/LO.
- HI/LO change only at reset, at the FINISH edge, or on an accepted MT write. They are stable while busy.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done exactly 33 cycles after start; HI=0xFFFFFFFE, LO=0x00000001, dz=0; busy high for 33 cycles.
- MULT A=-3 (0xFFFFFFFD) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=11 B=10 -> LO=1, HI=1. DIVU A=5 B=0 -> LO=0xFFFFFFFF, HI=5, dz=1 with done; a following MULTU 2*3 -> HI=0, LO=6, dz=0.
- Pulse start with new operands and hi_we=1 at cycles 5 and 20 of a MULTU 7*9 -> both ignored; result HI=0, LO=63. A second start in the done cycle (DIVU 100/7) -> accepted; LO=14, HI=2 33 cycles later.
- rst_n low asynchronously (mid-cycle) at cycle 10 of a DIV -> HI=LO=0, busy=0 immediately, no done pulse. After release, MULT -1*-1 -> HI=0, LO=1.
- Idle lo_we=1 WD=0x1234 then hi_we=1 WD=0xABCD -> LO=0x1234, HI=0xABCD next edge, done stays 0.
